vx_gbar_arbiter: RTL and testbench
==================================

// Module: vx_gbar_arbiter
// PURPOSE
//   Cluster-level global-barrier controller serving the per-core gbar request ports of all
//   cores in a cluster. Round-robin arbitrates one barrier arrival per cycle, tracks which
//   cores have arrived at each barrier ID, and broadcasts a one-cycle release response to
//   every core once the requested core count is reached.
// PARAMETERS
//   NUM_CORES     4   requesting cores (>=2)
//   NUM_BARRIERS  8   barrier IDs tracked (>=1)
//   NC_WIDTH      `LOG2UP(NUM_CORES)      core-id / size_m1 width (derived)
//   NB_WIDTH      `LOG2UP(NUM_BARRIERS)   barrier-id width (derived)
// PORTS
//   clk          in   1                     clock
//   reset        in   1                     asynchronous, active-low reset (0 = in reset)
//   req_valid    in   NUM_CORES             per-core arrival request
//   req_id       in   NUM_CORES*NB_WIDTH    per-core barrier ID
//   req_size_m1  in   NUM_CORES*NC_WIDTH    per-core participating core count minus 1
//   req_core_id  in   NUM_CORES*NC_WIDTH    per-core self ID (slot i must carry i)
//   req_ready    out  NUM_CORES             one-hot grant; request i accepted when valid&ready
//   rsp_valid    out  1                     release broadcast, one-cycle pulse
//   rsp_id       out  NB_WIDTH              released barrier ID
//   busy         out  1                     any barrier has >=1 arrived core
//   err          out  1                     sticky protocol-error flag
// BEHAVIOUR
//   Reset (reset==0, async): all arrival masks 0, rr pointer 0, rsp_valid 0, rsp_id 0, err 0,
//     busy 0. req_ready 0 while in reset. Exiting reset is synchronous to clk.
//   Arbitration: combinational round-robin over req_valid starting at rr pointer; at most one
//     req_ready bit high per cycle; req_ready never depends on rsp state (no backpressure).
//     After a grant to core g, pointer <= (g+1) mod NUM_CORES; no grant -> pointer holds.
//     A requester must hold valid/id/size stable until accepted.
//   Per-barrier state (mask[b], NUM_CORES bits): IDLE (mask==0) -> FILLING on first accepted
//     arrival -> back to IDLE on release. Accepted arrival (core g, id b, size s):
//       next = mask[b] | onehot(g); cnt = popcount(next), width NC_WIDTH+1;
//       cnt == s+1 (computed NC_WIDTH+1 wide, no wrap) -> release: mask[b] <= 0,
//         rsp_valid <= 1, rsp_id <= b on the next edge;
//       else mask[b] <= next.
//   Latency: arrival accepted at edge N -> rsp_valid high for exactly cycle N+1. Back-to-back
//     releases (different or same ID) produce back-to-back pulses, one per cycle.
//   size_m1 is taken from the completing request; mismatched sizes among cores are not
//     checked. size_m1+1 == 1 releases immediately on that core's arrival.
//   Duplicate arrival (mask[b][g] already 1): request is accepted (ready high), mask unchanged,
//     no release, err <= 1 (sticky until reset).
//   req_core_id != slot index on an accepted request: err <= 1; slot index is used.
//   size_m1+1 > NUM_CORES: barrier can never release; no timeout here (core-side watchdog).
//   Re-arrival at a just-released ID in the cycle after release starts a new epoch cleanly.
//   busy = |(all masks), registered view of state (reflects masks after the last edge).
//   Reset asserted mid-operation: all arrivals discarded; any pending rsp pulse is cancelled.
// TESTING
//   1. NUM_CORES=4: cores 0..3 each request id 2, size_m1=3, all valid together -> grants
//      in order 0,1,2,3 on 4 consecutive cycles; single rsp_valid with rsp_id=2 the cycle
//      after core 3's grant; busy 1 during fill, 0 after.
//   2. Cores 0,1 request id 1 size_m1=1 while cores 2,3 request id 5 size_m1=1, all concurrent
//      -> two releases (ids 1 and 5), masks of both return to 0, err stays 0.
//   3. Core 1 requests id 0 size_m1=2, then core 1 again id 0 -> second accepted, err=1,
//      no rsp; then cores 0,2 arrive -> release id 0 after core 2's grant.
//   4. Fairness: core 0 holds req_valid continuously, cores 1..3 request once each ->
//      each of cores 1..3 granted within 4 cycles; no core starved.
//   5. size_m1=0 from core 3, id 7 -> rsp_valid, rsp_id=7 exactly one cycle after grant.
//   6. Cores 0,1 arrive at id 4 (size_m1=3), assert reset=0 for 2 cycles -> masks/busy/err 0,
//      no rsp; after reset, cores 2,3 arriving alone do not release id 4.

Source files
------------

// File: rtl/vx_gbar_arbiter.sv
// Cluster global-barrier controller: round-robin accepts one barrier arrival per
// cycle, tracks arrived cores per barrier ID, and broadcasts a one-cycle release.
module vx_gbar_arbiter #(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned NUM_BARRIERS = 8,
  parameter int unsigned NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int unsigned NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
  input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
  input  logic [NUM_CORES*NC_WIDTH-1:0] req_core_id,
  output logic [NUM_CORES-1:0]          req_ready,
  output logic                         rsp_valid,
  output logic [NB_WIDTH-1:0]           rsp_id,
  output logic                         busy,
  output logic                         err
);

  localparam logic [NC_WIDTH-1:0] LastCore = NC_WIDTH'(NUM_CORES - 1);
  localparam logic [NC_WIDTH-1:0] CoreOne  = NC_WIDTH'(1);
  localparam logic [NC_WIDTH:0]   CntOne   = (NC_WIDTH + 1)'(1);

  logic [NC_WIDTH-1:0]                    rr_q, rr_d;
  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_q, mask_d;
  logic                                   rsp_valid_q, rsp_valid_d;
  logic [NB_WIDTH-1:0]                    rsp_id_q, rsp_id_d;
  logic                                   err_q, err_d;

  logic                  grant_vld;
  logic [NC_WIDTH-1:0]   grant_idx;
  logic [NC_WIDTH-1:0]   cand;
  logic [NB_WIDTH-1:0]   acc_id;
  logic [NC_WIDTH-1:0]   acc_size;
  logic [NC_WIDTH-1:0]   acc_cid;
  logic [NUM_CORES-1:0]  cur_mask;
  logic [NUM_CORES-1:0]  acc_next;
  logic [NC_WIDTH:0]     acc_cnt;
  logic                  acc_dup;
  logic                  acc_bad_id;

  // Round-robin pick: first valid request at or after the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = NC_WIDTH'((32'(rr_q) + k) % NUM_CORES);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant is suppressed while reset is held so nothing is consumed during reset.
  assign req_ready = (grant_vld && reset) ? (NUM_CORES'(1) << grant_idx) : '0;

  // Apply the accepted arrival to its barrier mask and decide on release.
  always_comb begin
    rr_d        = rr_q;
    mask_d      = mask_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    err_d       = err_q;

    acc_id     = req_id[grant_idx*NB_WIDTH +: NB_WIDTH];
    acc_size   = req_size_m1[grant_idx*NC_WIDTH +: NC_WIDTH];
    acc_cid    = req_core_id[grant_idx*NC_WIDTH +: NC_WIDTH];
    acc_bad_id = 32'(acc_id) >= NUM_BARRIERS;
    cur_mask   = acc_bad_id ? '0 : mask_q[acc_id];
    acc_dup    = cur_mask[grant_idx];
    acc_next   = cur_mask | (NUM_CORES'(1) << grant_idx);
    acc_cnt    = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      acc_cnt = acc_cnt + (NC_WIDTH + 1)'(acc_next[i]);
    end

    if (grant_vld) begin
      rr_d = (grant_idx == LastCore) ? '0 : grant_idx + CoreOne;
      if (acc_cid != grant_idx || acc_dup || acc_bad_id) begin
        err_d = 1'b1;
      end
      if (!acc_dup && !acc_bad_id) begin
        // Count compared one bit wider than size_m1 so size_m1+1 never wraps.
        if (acc_cnt == ({1'b0, acc_size} + CntOne)) begin
          mask_d[acc_id] = '0;
          rsp_valid_d    = 1'b1;
          rsp_id_d       = acc_id;
        end else begin
          mask_d[acc_id] = acc_next;
        end
      end
    end
  end

  // State registers; async reset discards arrivals and any pending release pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q        <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = |mask_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vx_gbar_arbiter.sv
// Bench for vx_gbar_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a set-based barrier model.
module tb_vx_gbar_arbiter;
  localparam int NC  = 4;
  localparam int NB  = 8;
  localparam int NCW = 2;
  localparam int NBW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     req_valid;
  logic [NC*NBW-1:0] req_id;
  logic [NC*NCW-1:0] req_size_m1;
  logic [NC*NCW-1:0] req_core_id;
  logic [NC-1:0]     req_ready;
  logic              rsp_valid;
  logic [NBW-1:0]    rsp_id;
  logic              busy;
  logic              err;

  vx_gbar_arbiter #(
    .NUM_CORES   (NC),
    .NUM_BARRIERS(NB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_id     (req_id),
    .req_size_m1(req_size_m1),
    .req_core_id(req_core_id),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each barrier is a set of arrived cores (bitmask), plus rr pointer and flags.
  int m_mask[NB];
  int m_rr;
  bit m_rsp_valid;
  int m_rsp_id;
  bit m_err;

  // Compare process: check registered outputs and the grant, then advance the model.
  always @(negedge clk) begin
    int g;
    int b;
    int s;
    int cid;
    int any_busy;
    logic [NC-1:0] exp_rdy;
    if (!reset) begin
      for (int i = 0; i < NB; i++) m_mask[i] = 0;
      m_rr = 0;
      m_rsp_valid = 0;
      m_rsp_id = 0;
      m_err = 0;
      chk("ready_in_reset", 32'(req_ready), 0);
      chk("rsp_valid_in_reset", 32'(rsp_valid), 0);
      chk("rsp_id_in_reset", 32'(rsp_id), 0);
      chk("busy_in_reset", 32'(busy), 0);
      chk("err_in_reset", 32'(err), 0);
    end else begin
      any_busy = 0;
      for (int i = 0; i < NB; i++) if (m_mask[i] != 0) any_busy = 1;
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      if (m_rsp_valid) chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
      chk("busy", 32'(busy), 32'(any_busy));
      chk("err", 32'(err), 32'(m_err));
      g = -1;
      for (int k = 0; k < NC; k++) begin
        if (g < 0 && req_valid[(m_rr + k) % NC]) g = (m_rr + k) % NC;
      end
      exp_rdy = (g < 0) ? '0 : NC'(1 << g);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      m_rsp_valid = 0;
      if (g >= 0) begin
        b   = int'(req_id[g*NBW +: NBW]);
        s   = int'(req_size_m1[g*NCW +: NCW]);
        cid = int'(req_core_id[g*NCW +: NCW]);
        if (cid != g) m_err = 1;
        if (m_mask[b][g]) begin
          m_err = 1;
        end else begin
          m_mask[b] = m_mask[b] | (1 << g);
          if ($countones(m_mask[b]) == s + 1) begin
            m_mask[b] = 0;
            m_rsp_valid = 1;
            m_rsp_id = b;
          end
        end
        m_rr = (g + 1) % NC;
      end
    end
  end

  // Requester state and observation log.
  bit [NC-1:0] pend;
  bit [NC-1:0] hold;
  int pid[NC];
  int psz[NC];
  int pcid[NC];
  int gcyc[NC];
  int rsp_cnt;
  int rsp_last;
  int rsp_cyc;
  int cyc = 0;

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      req_valid[c]                = pend[c];
      req_id[c*NBW +: NBW]        = NBW'(pid[c]);
      req_size_m1[c*NCW +: NCW]   = NCW'(psz[c]);
      req_core_id[c*NCW +: NCW]   = NCW'(pcid[c]);
    end
  endtask

  task automatic step();
    logic [NC-1:0] acc;
    drive();
    @(negedge clk);
    acc = req_valid & req_ready;
    for (int c = 0; c < NC; c++) if (acc[c] === 1'b1) gcyc[c] = cyc;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_last = int'(rsp_id);
      rsp_cyc = cyc;
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) if (acc[c] === 1'b1 && !hold[c]) pend[c] = 1'b0;
    cyc++;
  endtask

  task automatic set_req(input int c, input int id, input int sz);
    pend[c] = 1'b1;
    pid[c]  = id;
    psz[c]  = sz;
    pcid[c] = c;
  endtask

  task automatic clear_log();
    rsp_cnt = 0;
    rsp_last = -1;
    rsp_cyc = -1;
    for (int c = 0; c < NC; c++) gcyc[c] = -1;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (pend != '0 && n < max_cyc) begin
      step();
      n++;
    end
    chk(name, 32'(pend), 0);
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    pend = '0;
    hold = '0;
    for (int c = 0; c < NC; c++) begin
      pid[c] = 0;
      psz[c] = 0;
      pcid[c] = c;
    end
    clear_log();
    reset = 1'b0;
    // Requests present during reset must not be granted.
    set_req(0, 1, 0);
    step();
    chk("lit_reset_ready", 32'(req_ready), 0);
    step();
    pend = '0;
    reset = 1'b1;
    step();

    // Scenario 1: four cores to id 2, size 4.
    clear_log();
    for (int c = 0; c < NC; c++) set_req(c, 2, 3);
    wait_idle("t1_timeout", 20);
    chk("t1_g01", 32'(gcyc[1] - gcyc[0]), 1);
    chk("t1_g12", 32'(gcyc[2] - gcyc[1]), 1);
    chk("t1_g23", 32'(gcyc[3] - gcyc[2]), 1);
    chk("t1_rsp_cnt", 32'(rsp_cnt), 1);
    chk("t1_rsp_id", 32'(rsp_last), 2);
    chk("t1_rsp_lat", 32'(rsp_cyc - gcyc[3]), 1);
    chk("t1_busy_after", 32'(busy), 0);

    // Scenario 2: two concurrent pairs on ids 1 and 5.
    clear_log();
    set_req(0, 1, 1);
    set_req(1, 1, 1);
    set_req(2, 5, 1);
    set_req(3, 5, 1);
    wait_idle("t2_timeout", 20);
    chk("t2_rsp_cnt", 32'(rsp_cnt), 2);
    chk("t2_last_id", 32'(rsp_last), 5);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_err", 32'(err), 0);

    // Scenario 5: single-core barrier releases one cycle after grant.
    clear_log();
    set_req(3, 7, 0);
    wait_idle("t5_timeout", 10);
    chk("t5_rsp_cnt", 32'(rsp_cnt), 1);
    chk("t5_rsp_id", 32'(rsp_last), 7);
    chk("t5_rsp_lat", 32'(rsp_cyc - gcyc[3]), 1);

    // Scenario 4: core 0 hammers; cores 1..3 must still be served promptly.
    clear_log();
    begin
      int start;
      start = cyc;
      hold[0] = 1'b1;
      set_req(0, 3, 0);
      for (int c = 1; c < NC; c++) set_req(c, 6, 2);
      repeat (6) step();
      for (int c = 1; c < NC; c++) begin
        chk($sformatf("t4_fair_core%0d", c), 32'(gcyc[c] >= 0 && gcyc[c] - start < 4), 1);
      end
      hold[0] = 1'b0;
      wait_idle("t4_timeout", 10);
    end

    // Scenario 3: duplicate arrival flags err without releasing.
    clear_log();
    set_req(1, 0, 2);
    wait_idle("t3a_timeout", 10);
    set_req(1, 0, 2);
    wait_idle("t3b_timeout", 10);
    chk("t3_err", 32'(err), 1);
    chk("t3_no_rsp", 32'(rsp_cnt), 0);
    set_req(0, 0, 2);
    wait_idle("t3c_timeout", 10);
    set_req(2, 0, 2);
    wait_idle("t3d_timeout", 10);
    chk("t3_rsp_cnt", 32'(rsp_cnt), 1);
    chk("t3_rsp_id", 32'(rsp_last), 0);
    chk("t3_rsp_lat", 32'(rsp_cyc - gcyc[2]), 1);

    // Scenario 6: reset mid-fill discards arrivals.
    clear_log();
    set_req(0, 4, 3);
    set_req(1, 4, 3);
    wait_idle("t6a_timeout", 10);
    chk("t6_busy_before", 32'(busy), 1);
    reset = 1'b0;
    step();
    step();
    chk("t6_busy_reset", 32'(busy), 0);
    chk("t6_err_reset", 32'(err), 0);
    reset = 1'b1;
    set_req(2, 4, 3);
    set_req(3, 4, 3);
    wait_idle("t6b_timeout", 10);
    chk("t6_no_rsp", 32'(rsp_cnt), 0);
    chk("t6_busy_after", 32'(busy), 1);

    // Random traffic, including protocol errors and a mid-run reset.
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NC; c++) begin
        if (!pend[c] && $urandom_range(2) == 0) begin
          set_req(c, int'($urandom_range(4)), int'($urandom_range(3)));
          if ($urandom_range(15) == 0) pcid[c] = (c + 1) % NC;
        end
      end
      if (i == 400) reset = 1'b0;
      if (i == 402) reset = 1'b1;
      step();
    end
    wait_idle("rand_drain_timeout", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
